pipe_hold_ctrl: RTL

Central pipeline hold/flush sequencer for the 5-stage RISC-V core. It consumes hold requests from three sources and drives per-stage hold/flush controls plus the PC redirect:
- the load-use hazard detector (`hazard_hold`),
- the EX-stage branch/jump resolver,
- the data-memory wait signal.

It captures jumps that arrive during memory stalls, enforces a memory-wait timeout, and keeps stall statistics.

---
 rtl/pipe_hold_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush sequencer: merges load-use, jump and memory-wait requests
// into per-stage hold/flush controls, PC redirect, timeout flag and stall stats.
module pipe_hold_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hazard_hold_i,
    input  logic              jump_req_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              mem_busy_i,
    output logic              hold_pc_o,
    output logic              hold_if_id_o,
    output logic              hold_id_ex_o,
    output logic              hold_ex_mem_o,
    output logic              hold_mem_wb_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              jump_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              bus_err_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic              hold_all, hold_front, fl_if_id, fl_id_ex, jmp, run_prio, bubble;
    logic [ADDR_W-1:0] jaddr;

    always_comb begin
        hold_all    = 1'b0;
        hold_front  = 1'b0;
        fl_if_id    = 1'b0;
        fl_id_ex    = 1'b0;
        jmp         = 1'b0;
        jaddr       = '0;
        run_prio    = 1'b0;
        bubble      = 1'b0;
        state_d     = state_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        wait_cnt_d  = wait_cnt_q;
        bus_err_d   = bus_err_q;
        case (state_q)
            S_RUN: begin
                if (mem_busy_i) begin
                    hold_all   = 1'b1;
                    wait_cnt_d = WCW'(1);
                    state_d    = S_WAIT;
                    if (jump_req_i) begin
                        pend_vld_d  = 1'b1;
                        pend_addr_d = jump_addr_i;
                    end
                end else begin
                    run_prio = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_busy_i) begin
                    hold_all = 1'b1;
                    if (jump_req_i) begin
                        pend_vld_d  = 1'b1;
                        pend_addr_d = jump_addr_i;
                    end
                    // The busy cycle that brings the streak to MAX_WAIT trips the timeout.
                    if (wait_cnt_q == WAIT_LAST) begin
                        bus_err_d  = 1'b1;
                        state_d    = S_ERR;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end else begin
                    pend_vld_d = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = S_RUN;
                    if (pend_vld_q || jump_req_i) begin
                        jmp      = 1'b1;
                        jaddr    = jump_req_i ? jump_addr_i : pend_addr_q;
                        fl_if_id = 1'b1;
                        fl_id_ex = 1'b1;
                    end else begin
                        run_prio = 1'b1;
                    end
                end
            end
            S_ERR: begin
                hold_all = 1'b1;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // A resolved jump flushes the younger instruction, so a coincident hazard is moot.
        if (run_prio) begin
            if (jump_req_i) begin
                jmp      = 1'b1;
                jaddr    = jump_addr_i;
                fl_if_id = 1'b1;
                fl_id_ex = 1'b1;
            end else if (hazard_hold_i) begin
                hold_front = 1'b1;
                fl_id_ex   = 1'b1;
                bubble     = 1'b1;
            end
        end

        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if ((hold_all || hold_front) && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (bubble && bubble_cnt_q != '1)
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            pend_vld_q   <= 1'b0;
            pend_addr_q  <= '0;
            wait_cnt_q   <= '0;
            bus_err_q    <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pend_vld_q   <= pend_vld_d;
            pend_addr_q  <= pend_addr_d;
            wait_cnt_q   <= wait_cnt_d;
            bus_err_q    <= bus_err_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Every output is forced low while reset is held, including registered ones.
    assign hold_pc_o     = rst_n & (hold_all | hold_front);
    assign hold_if_id_o  = rst_n & (hold_all | hold_front);
    assign hold_id_ex_o  = rst_n & hold_all;
    assign hold_ex_mem_o = rst_n & hold_all;
    assign hold_mem_wb_o = rst_n & hold_all;
    assign flush_if_id_o = rst_n & fl_if_id;
    assign flush_id_ex_o = rst_n & fl_id_ex;
    assign jump_o        = rst_n & jmp;
    assign jump_addr_o   = rst_n ? jaddr : '0;
    assign bus_err_o     = rst_n & bus_err_q;
    assign stall_cnt_o   = rst_n ? stall_cnt_q : '0;
    assign bubble_cnt_o  = rst_n ? bubble_cnt_q : '0;

endmodule
